// File: rtl/pong_message_decoder.sv
// rtl/pong_message_decoder.sv - oversampling receiver and field decoder for the inter-board pong link
// Optional parity bit and PARITY state are compiled in by defining PARITY_CHECK_EN.
module pong_message_decoder #(
    parameter int BIT_CYCLES = 50
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       NEO_IN,
    input  logic       message_acked,
    output logic       new_message_received,
    output logic       ball_message_rx,
    output logic       miss_message_rx,
    output logic       new_game_message_rx,
    output logic       new_game_ack_message_rx,
    output logic [8:0] ball_y_rx,
    output logic [3:0] velocity_x_rx,
    output logic [3:0] velocity_y_rx,
    output logic       sign_y_rx,
    output logic [4:0] my_score_rx,
    output logic [4:0] your_score_rx,
    output logic       you_should_serve_rx,
    output logic       you_serve_first_rx,
    output logic       frame_error,
    output logic       overrun
);

    localparam int CW = $clog2(BIT_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] C_HALF = CW'(BIT_CYCLES / 2 - 1);

    typedef enum logic [2:0] {
        S_ARM,
        S_IDLE,
        S_START,
        S_DATA,
`ifdef PARITY_CHECK_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic           r_sync1;
    logic           r_sync2;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_bit_cnt;
    logic [23:0]    r_shift;
    logic           w_cnt_clr;
    logic           w_shift_en;
    logic           w_done;
    logic           w_frame_ok;
    logic           w_frame_good;
    logic           w_frame_bad;
    logic           w_ack_take;
    logic           w_pending;
    logic           w_is_ball;
    logic           w_is_miss;
    logic           w_is_new_game;
    logic           w_is_ack;
`ifdef PARITY_CHECK_EN
    logic           r_par_ok;
    logic           w_par_en;
`endif

    // Two-flop synchronizer; reset low so ARM must observe a genuinely high line.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= NEO_IN;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_state <= S_ARM;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_clr    = 1'b0;
        w_shift_en   = 1'b0;
        w_done       = 1'b0;
`ifdef PARITY_CHECK_EN
        w_par_en     = 1'b0;
`endif
        case (r_state)
            S_ARM: begin
                if (r_sync2) begin
                    w_next_state = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!r_sync2) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = S_START;
                end
            end
            S_START: begin
                if (r_cnt == C_HALF) begin
                    w_cnt_clr    = 1'b1;
                    w_next_state = r_sync2 ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_cnt == 5'd23) begin
`ifdef PARITY_CHECK_EN
                        w_next_state = S_PARITY;
`else
                        w_next_state = S_STOP;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            S_PARITY: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_par_en     = 1'b1;
                    w_next_state = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == C_LAST) begin
                    w_cnt_clr    = 1'b1;
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_ARM;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_cnt     <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CW'(1);
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
            end else if (w_shift_en) begin
                r_bit_cnt <= r_bit_cnt + 5'd1;
                r_shift   <= {r_shift[22:0], r_sync2};
            end
        end
    end

`ifdef PARITY_CHECK_EN
    // Even parity: the transmitted bit equals the XOR of the 24 data bits.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            r_par_ok <= 1'b0;
        end else if (w_par_en) begin
            r_par_ok <= (r_sync2 == ^r_shift);
        end
    end

    assign w_frame_ok = r_sync2 & r_par_ok;
`else
    assign w_frame_ok = r_sync2;
`endif

    assign w_frame_good  = w_done & w_frame_ok;
    assign w_frame_bad   = w_done & ~w_frame_ok;
    assign w_ack_take    = message_acked & new_message_received;
    // Pending after this edge's ack is applied, so a same-cycle ack frees the slot.
    assign w_pending     = new_message_received & ~message_acked;
    assign w_is_ball     = (r_shift[23:22] == 2'b00);
    assign w_is_miss     = (r_shift[23:22] == 2'b01);
    assign w_is_new_game = (r_shift[23:22] == 2'b10);
    assign w_is_ack      = (r_shift[23:22] == 2'b11);

    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            new_message_received    <= 1'b0;
            ball_message_rx         <= 1'b0;
            miss_message_rx         <= 1'b0;
            new_game_message_rx     <= 1'b0;
            new_game_ack_message_rx <= 1'b0;
            ball_y_rx               <= '0;
            velocity_x_rx           <= '0;
            velocity_y_rx           <= '0;
            sign_y_rx               <= 1'b0;
            my_score_rx             <= '0;
            your_score_rx           <= '0;
            you_should_serve_rx     <= 1'b0;
            you_serve_first_rx      <= 1'b0;
            frame_error             <= 1'b0;
            overrun                 <= 1'b0;
        end else begin
            frame_error <= w_frame_bad;
            if (w_ack_take) begin
                new_message_received    <= 1'b0;
                ball_message_rx         <= 1'b0;
                miss_message_rx         <= 1'b0;
                new_game_message_rx     <= 1'b0;
                new_game_ack_message_rx <= 1'b0;
                overrun                 <= 1'b0;
            end
            if (w_frame_good) begin
                if (w_pending) begin
                    overrun <= 1'b1;
                end else begin
                    new_message_received    <= 1'b1;
                    ball_message_rx         <= w_is_ball;
                    miss_message_rx         <= w_is_miss;
                    new_game_message_rx     <= w_is_new_game;
                    new_game_ack_message_rx <= w_is_ack;
                    ball_y_rx               <= w_is_ball ? r_shift[21:13] : 9'd0;
                    velocity_x_rx           <= w_is_ball ? r_shift[12:9]  : 4'd0;
                    velocity_y_rx           <= w_is_ball ? r_shift[8:5]   : 4'd0;
                    sign_y_rx               <= w_is_ball & r_shift[4];
                    my_score_rx             <= w_is_miss ? r_shift[21:17] : 5'd0;
                    your_score_rx           <= w_is_miss ? r_shift[16:12] : 5'd0;
                    you_should_serve_rx     <= w_is_miss & r_shift[11];
                    you_serve_first_rx      <= w_is_new_game & r_shift[21];
                end
            end
        end
    end

endmodule

// File: tb/tb_pong_message_decoder.sv
// tb/tb_pong_message_decoder.sv - self-checking bench for pong_message_decoder
// Sends parity bits only when PARITY_CHECK_EN is defined, matching the DUT build.
module tb_pong_message_decoder;

    localparam int BC = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       NEO_IN;
    logic       message_acked;
    logic       new_message_received;
    logic       ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx;
    logic [8:0] ball_y_rx;
    logic [3:0] velocity_x_rx, velocity_y_rx;
    logic       sign_y_rx;
    logic [4:0] my_score_rx, your_score_rx;
    logic       you_should_serve_rx, you_serve_first_rx;
    logic       frame_error, overrun;

    always #5 clk = ~clk;

    pong_message_decoder #(.BIT_CYCLES(BC)) dut (
        .CLOCK_50               (clk),
        .reset_n                (reset_n),
        .NEO_IN                 (NEO_IN),
        .message_acked          (message_acked),
        .new_message_received   (new_message_received),
        .ball_message_rx        (ball_message_rx),
        .miss_message_rx        (miss_message_rx),
        .new_game_message_rx    (new_game_message_rx),
        .new_game_ack_message_rx(new_game_ack_message_rx),
        .ball_y_rx              (ball_y_rx),
        .velocity_x_rx          (velocity_x_rx),
        .velocity_y_rx          (velocity_y_rx),
        .sign_y_rx              (sign_y_rx),
        .my_score_rx            (my_score_rx),
        .your_score_rx          (your_score_rx),
        .you_should_serve_rx    (you_should_serve_rx),
        .you_serve_first_rx     (you_serve_first_rx),
        .frame_error            (frame_error),
        .overrun                (overrun)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: state of the held message, tracked per whole frame.
    logic       m_nmr, m_ovr, m_sign, m_serve, m_first;
    logic [3:0] m_type;
    logic [8:0] m_y;
    logic [3:0] m_vx, m_vy;
    logic [4:0] m_my, m_your;
    int         m_err = 0;

    int fe_pulses = 0;
    int fe_long   = 0;
    bit fe_prev   = 0;

    always @(negedge clk) begin
        if (frame_error === 1'b1) fe_pulses++;
        if (frame_error === 1'b1 && fe_prev) fe_long++;
        fe_prev = (frame_error === 1'b1);
    end

    typedef struct {
        logic [23:0] data;
        logic        stop;
        logic        ack;
        logic        exp_nmr;
        logic [3:0]  exp_type;
        logic        exp_ovr;
        int          exp_err_inc;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_nmr = 0; m_ovr = 0; m_type = 0; m_y = 0; m_vx = 0; m_vy = 0;
        m_sign = 0; m_my = 0; m_your = 0; m_serve = 0; m_first = 0;
    endtask

    task automatic model_ack();
        if (m_nmr) begin
            m_nmr = 0; m_type = 0; m_ovr = 0;
        end
    endtask

    task automatic model_frame(input logic [23:0] d, input bit good);
        int di, t;
        di = int'({8'd0, d});
        t  = di / 4194304;
        if (!good) m_err++;
        else if (m_nmr) m_ovr = 1;
        else begin
            m_nmr = 1; m_type = 4'b1000 >> t;
            m_y = 0; m_vx = 0; m_vy = 0; m_sign = 0; m_my = 0; m_your = 0; m_serve = 0; m_first = 0;
            if (t == 0) begin
                m_y = 9'((di / 8192) % 512); m_vx = 4'((di / 512) % 16);
                m_vy = 4'((di / 32) % 16); m_sign = 1'((di / 16) % 2);
            end else if (t == 1) begin
                m_my = 5'((di / 131072) % 32); m_your = 5'((di / 4096) % 32);
                m_serve = 1'((di / 2048) % 2);
            end else if (t == 2) begin
                m_first = 1'((di / 2097152) % 2);
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".nmr"},   32'(new_message_received), 32'(m_nmr));
        chk({tag, ".type"},  32'({ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx}), 32'(m_type));
        chk({tag, ".y"},     32'(ball_y_rx), 32'(m_y));
        chk({tag, ".vx"},    32'(velocity_x_rx), 32'(m_vx));
        chk({tag, ".vy"},    32'(velocity_y_rx), 32'(m_vy));
        chk({tag, ".sign"},  32'(sign_y_rx), 32'(m_sign));
        chk({tag, ".my"},    32'(my_score_rx), 32'(m_my));
        chk({tag, ".your"},  32'(your_score_rx), 32'(m_your));
        chk({tag, ".serve"}, 32'(you_should_serve_rx), 32'(m_serve));
        chk({tag, ".first"}, 32'(you_serve_first_rx), 32'(m_first));
        chk({tag, ".ovr"},   32'(overrun), 32'(m_ovr));
        chk({tag, ".ferr"},  32'(fe_pulses), 32'(m_err));
    endtask

    task automatic send_bit(input logic b);
        NEO_IN = b;
        repeat (BC) cyc();
    endtask

    // ack_at_load pulses message_acked on the edge that commits the stop-bit sample.
    task automatic send_frame(input logic [23:0] d, input bit par_flip, input logic stop, input bit ack_at_load);
        bit good;
        send_bit(1'b0);
        for (int i = 23; i >= 0; i--) send_bit(d[i]);
`ifdef PARITY_CHECK_EN
        send_bit((^d) ^ par_flip);
        good = stop && !par_flip;
`else
        good = stop;
`endif
        NEO_IN = stop;
        if (ack_at_load) begin
            repeat (6) cyc();
            message_acked = 1'b1;
            cyc();
            message_acked = 1'b0;
            repeat (BC - 7) cyc();
            model_ack();
        end else begin
            repeat (BC) cyc();
        end
        NEO_IN = 1'b1;
        model_frame(d, good);
    endtask

    task automatic do_ack();
        message_acked = 1'b1;
        cyc();
        message_acked = 1'b0;
        model_ack();
    endtask

    initial begin
        int e0;
        vecs[0] = '{24'h258A70, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 0};
        vecs[1] = '{24'h467800, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b0, 0};
        vecs[2] = '{24'h800000, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 0};
        vecs[3] = '{24'h258A70, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 1};
        vecs[4] = '{24'hC00000, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b0, 0};
        vecs[5] = '{24'hA00000, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b0, 0};
        vecs[6] = '{24'h3FFFFF, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1};

        reset_n = 1'b0; NEO_IN = 1'b1; message_acked = 1'b0;
        model_clear();
        repeat (3) cyc();
        check_all("reset");
        reset_n = 1'b1;
        repeat (4) cyc();

        for (int v = 0; v < 7; v++) begin
            e0 = fe_pulses;
            send_frame(vecs[v].data, 1'b0, vecs[v].stop, 1'b0);
            repeat (4) cyc();
            check_all($sformatf("vec%0d", v));
            chk($sformatf("vec%0d.tbl_nmr", v), 32'(new_message_received), 32'(vecs[v].exp_nmr));
            chk($sformatf("vec%0d.tbl_type", v), 32'({ball_message_rx, miss_message_rx, new_game_message_rx, new_game_ack_message_rx}), 32'(vecs[v].exp_type));
            chk($sformatf("vec%0d.tbl_ovr", v), 32'(overrun), 32'(vecs[v].exp_ovr));
            chk($sformatf("vec%0d.tbl_err", v), 32'(fe_pulses - e0), 32'(vecs[v].exp_err_inc));
            if (v == 0) begin
                chk("ball.y300", 32'(ball_y_rx), 32'd300);
                chk("ball.vx5",  32'(velocity_x_rx), 32'd5);
                chk("ball.vy3",  32'(velocity_y_rx), 32'd3);
                chk("ball.sign", 32'(sign_y_rx), 32'd1);
            end
            if (vecs[v].ack) begin
                do_ack();
                cyc();
                check_all($sformatf("vec%0d.ack", v));
            end
        end
        do_ack();
        cyc();

        // Miss immediately followed by new game: second one overruns.
        send_frame(24'h467800, 1'b0, 1'b1, 1'b0);
        send_frame(24'h800000, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc();
        check_all("b2b");
        chk("b2b.my3",   32'(my_score_rx), 32'd3);
        chk("b2b.your7", 32'(your_score_rx), 32'd7);
        chk("b2b.ovr",   32'(overrun), 32'd1);
        do_ack();
        cyc();
        check_all("b2b.ack");

`ifdef PARITY_CHECK_EN
        e0 = fe_pulses;
        send_frame(24'h258A70, 1'b1, 1'b1, 1'b0);
        repeat (4) cyc();
        check_all("badpar");
        chk("badpar.pulse", 32'(fe_pulses - e0), 32'd1);
`endif

        // Ack landing on the same edge as a new load: slot frees first, no overrun.
        send_frame(24'h258A70, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc();
        send_frame(24'h467800, 1'b0, 1'b1, 1'b1);
        repeat (4) cyc();
        check_all("same_cycle_ack");
        do_ack();
        cyc();

        // Short low glitch in IDLE must not start a frame.
        NEO_IN = 1'b0;
        repeat (3) cyc();
        NEO_IN = 1'b1;
        repeat (20) cyc();
        check_all("glitch");
        send_frame(24'hC00000, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc();
        check_all("glitch.ackframe");
        chk("glitch.ngack", 32'(new_game_ack_message_rx), 32'd1);

        // Reset in the middle of data bit 10 while the line is low.
        NEO_IN = 1'b0;
        repeat (BC * 11 + 2) cyc();
        reset_n = 1'b0;
        repeat (2) cyc();
        model_clear();
        check_all("midreset");
        reset_n = 1'b1;
        repeat (40) cyc();
        check_all("midreset.armed");
        NEO_IN = 1'b1;
        repeat (10) cyc();
        send_frame(24'h258A70, 1'b0, 1'b1, 1'b0);
        repeat (4) cyc();
        check_all("midreset.ball");
        do_ack();
        cyc();

        for (int r = 0; r < 24; r++) begin
            logic [23:0] d;
            logic        stop;
            bit          pf;
            d    = 24'($urandom);
            stop = ($urandom_range(0, 5) != 0);
`ifdef PARITY_CHECK_EN
            pf   = ($urandom_range(0, 5) == 0);
`else
            pf   = 1'b0;
`endif
            if ($urandom_range(0, 1) == 1) do_ack();
            send_frame(d, pf, stop, 1'b0);
            repeat (stop ? $urandom_range(0, 3) : 12) cyc();
            check_all($sformatf("rand%0d", r));
        end

        chk("fe_width", 32'(fe_long), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
